// File: rtl/bbox_pkg.sv
// Shared constants, bbox word layout and reader state encoding for the bbox store.
package bbox_pkg;

  localparam int unsigned NUM_BOXES  = 10;
  localparam int unsigned BBOX_W     = 64;
  localparam logic [63:0] EMPTY_CODE = 64'h1;

  localparam int unsigned FIELD_W    = 16;
  localparam int unsigned X_MIN_LSB  = 0;
  localparam int unsigned Y_MIN_LSB  = 16;
  localparam int unsigned X_MAX_LSB  = 32;
  localparam int unsigned Y_MAX_LSB  = 48;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND
  } state_e;

endpackage

// File: rtl/bbox_first_set.sv
// Lowest-set-bit priority encoder: reports whether any bit is set and the index of the lowest one.
module bbox_first_set #(
  parameter int unsigned N     = 10,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N-1:0]     vec,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i] && !found) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bbox_stream_reader.sv
// Snapshots all bbox slots on start and streams the occupied ones, lowest index first, over valid/ready.
module bbox_stream_reader #(
  parameter int unsigned        NUM_BOXES  = bbox_pkg::NUM_BOXES,
  parameter int unsigned        BBOX_W     = bbox_pkg::BBOX_W,
  parameter logic [BBOX_W-1:0]  EMPTY_CODE = BBOX_W'(bbox_pkg::EMPTY_CODE),
  parameter bit                 SKIP_EMPTY = 1'b1,
  localparam int unsigned       IDX_W      = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_BOXES*BBOX_W-1:0] bbox_flat,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [BBOX_W-1:0]           m_data,
  output logic [IDX_W-1:0]            m_index,
  output logic                        m_last,
  output logic                        busy,
  output logic                        done,
  output logic                        start_missed
);

  import bbox_pkg::*;

  state_e                 state_q, state_d;
  logic [BBOX_W-1:0]      shadow_q [NUM_BOXES];
  logic [BBOX_W-1:0]      shadow_d [NUM_BOXES];
  logic [NUM_BOXES-1:0]   mask_q, mask_d, mask_clr, fs_vec;
  logic [IDX_W-1:0]       idx_q, idx_d, fs_idx;
  logic                   fs_found;
  logic                   done_q, done_d, missed_q, missed_d;
  logic                   busy_int, start_ok;

  // The done cycle still counts as busy, so a start landing there is reported as missed.
  always_comb begin
    busy_int = (state_q != ST_IDLE) || done_q;
    start_ok = start && !busy_int;
    mask_clr = mask_q & ~(NUM_BOXES'(1) << idx_q);
    fs_vec   = (state_q == ST_SEND) ? mask_clr : mask_q;
  end

  bbox_first_set #(
    .N     (NUM_BOXES),
    .IDX_W (IDX_W)
  ) u_first_set (
    .vec   (fs_vec),
    .found (fs_found),
    .index (fs_idx)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    missed_d = start && busy_int;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          for (int unsigned k = 0; k < NUM_BOXES; k++) begin
            shadow_d[k] = bbox_flat[k*BBOX_W +: BBOX_W];
            mask_d[k]   = (bbox_flat[k*BBOX_W +: BBOX_W] != EMPTY_CODE) || !SKIP_EMPTY;
          end
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (fs_found) begin
          idx_d   = fs_idx;
          state_d = ST_SEND;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (m_ready) begin
          mask_d = mask_clr;
          if (fs_found) begin
            idx_d = fs_idx;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_BOXES; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    m_valid      = (state_q == ST_SEND);
    m_data       = shadow_q[idx_q];
    m_index      = idx_q;
    m_last       = m_valid && (mask_clr == '0);
    busy         = busy_int;
    done         = done_q;
    start_missed = missed_q;
  end

endmodule
